mfcc_feat_stream: RTL and testbench

//  Parametrised MFCC output stage with backpressure and delta coefficients.
//  - Follows the liftering step in the MFCC pipeline.
//  - On each frame_start, reads NUM_COEF liftered coefficients from the coefficient RAM.
//  - Optionally appends first-order deltas, each computed as the current frame minus the previous frame.
//  - Streams all words on a valid/ready interface, with optional gating by the VAD decision.

---
 rtl/mfcc_feat_stream.sv | 164 ++++++++++++++++
 tb/tb_mfcc_feat_stream.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfcc_feat_stream.sv
`default_nettype none
// mfcc_feat_stream: fetches one frame of liftered MFCCs from RAM, appends saturated
// frame-to-frame deltas and streams the words on a valid/ready port.  Rev 1.0
module mfcc_feat_stream #(
  parameter int DATA_W   = 26,
  parameter int NUM_COEF = 12,
  parameter int IDX_W    = 6,
  parameter int DELTA_EN = 1,
  parameter int VAD_GATE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              vad_in,
  output logic [4:0]        rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] x_o,
  output logic [IDX_W-1:0]  out_index,
  output logic              dv_out,
  input  logic              out_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int NTOT = NUM_COEF * ((DELTA_EN != 0) ? 2 : 1);
  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EMIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state_q;
  logic                     vad_q;
  logic                     have_prev_q;
  logic [4:0]               fetch_cnt_q;
  logic [4:0]               rd_addr_q;
  logic [DATA_W-1:0]        x_q;
  logic [IDX_W-1:0]         idx_q;
  logic                     dv_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     overrun_q;
  logic signed [DATA_W-1:0] cur_q  [NUM_COEF];
  logic signed [DATA_W-1:0] prev_q [NUM_COEF];
  logic signed [DATA_W-1:0] delta  [NUM_COEF];
  logic [IDX_W-1:0]         idx_d;
  logic [DATA_W-1:0]        x_d;

  // One extra bit of headroom makes the overflow test a simple sign-bit compare.
  for (genvar k = 0; k < NUM_COEF; k++) begin : g_delta
    logic signed [DATA_W:0] diff;
    assign diff = {cur_q[k][DATA_W-1], cur_q[k]} - {prev_q[k][DATA_W-1], prev_q[k]};
    assign delta[k] = !have_prev_q                      ? '0 :
                      (diff[DATA_W] != diff[DATA_W-1])  ? (diff[DATA_W] ? SAT_MIN : SAT_MAX) :
                                                          diff[DATA_W-1:0];
  end

  always_comb begin
    idx_d = idx_q + IDX_W'(1);
    x_d   = '0;
    for (int k = 0; k < NUM_COEF; k++) begin
      if (idx_d == IDX_W'(k)) x_d = cur_q[k];
      if ((DELTA_EN != 0) && (idx_d == IDX_W'(NUM_COEF + k))) x_d = delta[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      vad_q       <= 1'b0;
      have_prev_q <= 1'b0;
      fetch_cnt_q <= '0;
      rd_addr_q   <= '0;
      x_q         <= '0;
      idx_q       <= '0;
      dv_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int k = 0; k < NUM_COEF; k++) begin
        cur_q[k]  <= '0;
        prev_q[k] <= '0;
      end
    end else begin
      done_q    <= 1'b0;
      overrun_q <= frame_start && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            vad_q       <= vad_in;
            fetch_cnt_q <= '0;
            rd_addr_q   <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= S_FETCH;
          end
        end

        S_FETCH: begin
          // RAM data for address n arrives while the counter reads n+1.
          for (int k = 0; k < NUM_COEF; k++) begin
            if (fetch_cnt_q == 5'(k + 1)) cur_q[k] <= rd_data;
          end
          if (fetch_cnt_q == 5'(NUM_COEF)) begin
            fetch_cnt_q <= '0;
            rd_addr_q   <= '0;
            if ((VAD_GATE != 0) && !vad_q) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              dv_q    <= 1'b1;
              idx_q   <= '0;
              x_q     <= cur_q[0];
              state_q <= S_EMIT;
            end
          end else begin
            fetch_cnt_q <= fetch_cnt_q + 5'd1;
            rd_addr_q   <= (fetch_cnt_q < 5'(NUM_COEF - 1)) ? fetch_cnt_q + 5'd1 : 5'd0;
          end
        end

        S_EMIT: begin
          if (dv_q && out_ready) begin
            if (idx_q == IDX_W'(NTOT - 1)) begin
              dv_q    <= 1'b0;
              x_q     <= '0;
              idx_q   <= '0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              x_q   <= x_d;
              idx_q <= idx_d;
            end
          end
        end

        S_DONE: begin
          // Gated frames still become the delta reference for the next frame.
          for (int k = 0; k < NUM_COEF; k++) prev_q[k] <= cur_q[k];
          have_prev_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_addr    = rd_addr_q;
  assign x_o        = x_q;
  assign out_index  = idx_q;
  assign dv_out     = dv_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_mfcc_feat_stream.sv
`default_nettype none
// tb_mfcc_feat_stream: table-driven and randomized frames checked against a
// frame-level reference model of the MFCC output stage.
module tb_mfcc_feat_stream;
  localparam int     DATA_W = 26;
  localparam int     NC     = 12;
  localparam int     IDX_W  = 6;
  localparam int     NTOT   = 24;
  localparam longint SMAX   = 33554431;
  localparam longint SMIN   = -33554432;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_start;
  logic              vad_in;
  logic [4:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] x_o;
  logic [IDX_W-1:0]  out_index;
  logic              dv_out;
  logic              out_ready;
  logic              busy;
  logic              frame_done;
  logic              overrun;

  mfcc_feat_stream #(
    .DATA_W(DATA_W), .NUM_COEF(NC), .IDX_W(IDX_W), .DELTA_EN(1), .VAD_GATE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .vad_in(vad_in),
    .rd_addr(rd_addr), .rd_data(rd_data), .x_o(x_o), .out_index(out_index),
    .dv_out(dv_out), .out_ready(out_ready), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [32];
  always @(posedge clk) rd_data <= mem[rd_addr];

  typedef struct {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] val;
  } word_t;

  typedef struct {
    int                kind;
    bit                vad;
    int                mode;
    int                ovr_at;
    int                e_first;
    int                e_done;
    int                e_words;
    bit                chk_d0;
    logic [DATA_W-1:0] e_d0;
  } vec_t;

  int     total = 0;
  int     bad   = 0;
  word_t  exp_q[$];
  word_t  got_q[$];
  longint coef   [NC];
  longint prev_m [NC];
  bit     have_prev_m = 1'b0;
  int     cyc_g = 0;
  int     rmode = 0;
  int     ovr_cnt = 0;
  bit     stall_pend = 1'b0;
  logic [DATA_W-1:0] snap_x;
  logic [IDX_W-1:0]  snap_i;

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, got, want, $time);
    end
  endfunction

  function automatic longint rnd_coef();
    longint t;
    int sel;
    sel = $urandom_range(7, 0);
    if (sel == 0) return SMAX;
    if (sel == 1) return SMIN;
    t = longint'($urandom_range(67108863, 0));
    return t - 33554432;
  endfunction

  function automatic void fill(input int kind);
    for (int k = 0; k < NC; k++) begin
      case (kind)
        0:       coef[k] = k + 1;
        1:       coef[k] = 3;
        3:       coef[k] = SMIN;
        4:       coef[k] = SMAX;
        default: coef[k] = rnd_coef();
      endcase
    end
  endfunction

  // Frame-level reference: statics, then clamped differences to the previous frame.
  function automatic void model_frame(input bit vad);
    word_t  w;
    longint d;
    exp_q.delete();
    if (vad) begin
      for (int k = 0; k < NC; k++) begin
        w.idx = IDX_W'(k);
        w.val = DATA_W'(coef[k]);
        exp_q.push_back(w);
      end
      for (int k = 0; k < NC; k++) begin
        if (have_prev_m) d = coef[k] - prev_m[k];
        else             d = 0;
        if (d > SMAX) d = SMAX;
        if (d < SMIN) d = SMIN;
        w.idx = IDX_W'(NC + k);
        w.val = DATA_W'(d);
        exp_q.push_back(w);
      end
    end
    for (int k = 0; k < NC; k++) prev_m[k] = coef[k];
    have_prev_m = 1'b1;
  endfunction

  task automatic step();
    word_t w;
    @(negedge clk);
    cyc_g++;
    if (stall_pend) begin
      chk("stall_dv", 64'(dv_out), 64'd1);
      chk("stall_x", 64'(x_o), 64'(snap_x));
      chk("stall_idx", 64'(out_index), 64'(snap_i));
    end
    if (!dv_out) begin
      chk("idle_x", 64'(x_o), 64'd0);
      chk("idle_idx", 64'(out_index), 64'd0);
    end
    if (overrun) ovr_cnt++;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((cyc_g % 4) == 0) || ((cyc_g % 4) == 3);
      default: out_ready = ($urandom_range(2, 0) != 0);
    endcase
    if (dv_out && out_ready) begin
      w.idx = out_index;
      w.val = x_o;
      got_q.push_back(w);
    end
    stall_pend = dv_out && !out_ready;
    snap_x = x_o;
    snap_i = out_index;
  endtask

  // ovr_at > 0 pulses frame_start at that cycle; -2 pulses it during DONE.
  task automatic run_frame(input bit vad, input int mode, input int ovr_at,
                           output int first_dv, output int done_cyc);
    bit done;
    done = 1'b0;
    for (int k = 0; k < NC; k++) mem[k] = DATA_W'(coef[k]);
    model_frame(vad);
    got_q.delete();
    ovr_cnt  = 0;
    rmode    = mode;
    first_dv = -1;
    done_cyc = -1;
    frame_start = 1'b1;
    vad_in      = vad;
    for (int n = 1; n <= 400 && !done; n++) begin
      step();
      frame_start = 1'b0;
      vad_in      = 1'($urandom_range(1, 0));
      if (n == 1) chk("busy_fetch", 64'(busy), 64'd1);
      if (dv_out && first_dv < 0) first_dv = n;
      if (frame_done) begin
        done     = 1'b1;
        done_cyc = n;
        if (ovr_at == -2) frame_start = 1'b1;
      end
      if (n == ovr_at) frame_start = 1'b1;
    end
    chk("frame_done_seen", 64'(done), 64'd1);
    step();
    frame_start = 1'b0;
    chk("done_pulse_width", 64'(frame_done), 64'd0);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("overrun_count", 64'(ovr_cnt), (ovr_at != 0) ? 64'd1 : 64'd0);
    chk("word_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk("word_idx", 64'(got_q[i].idx), 64'(exp_q[i].idx));
      chk("word_val", 64'(got_q[i].val), 64'(exp_q[i].val));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [9];
    int   fd;
    int   dc;

    tbl[0] = '{0, 1'b1, 0,  0, 14, 38, 24, 1'b1, 26'h0000000};
    tbl[1] = '{1, 1'b1, 0,  0, 14, 38, 24, 1'b1, 26'h0000002};
    tbl[2] = '{2, 1'b1, 1,  0, 14,  0, 24, 1'b0, 26'h0000000};
    tbl[3] = '{2, 1'b0, 0,  0, -1, 14,  0, 1'b0, 26'h0000000};
    tbl[4] = '{2, 1'b1, 0,  0, 14, 38, 24, 1'b0, 26'h0000000};
    tbl[5] = '{3, 1'b1, 0,  0, 14, 38, 24, 1'b0, 26'h0000000};
    tbl[6] = '{4, 1'b1, 0,  0, 14, 38, 24, 1'b1, 26'h1FFFFFF};
    tbl[7] = '{3, 1'b1, 0,  0, 14, 38, 24, 1'b1, 26'h2000000};
    tbl[8] = '{2, 1'b1, 2, 20, 14,  0, 24, 1'b0, 26'h0000000};

    for (int i = 0; i < 32; i++) mem[i] = '0;
    for (int k = 0; k < NC; k++) prev_m[k] = 0;
    rst_n = 1'b0; frame_start = 1'b0; vad_in = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_x", 64'(x_o), 64'd0);
    chk("rst_idx", 64'(out_index), 64'd0);
    chk("rst_dv", 64'(dv_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_addr", 64'(rd_addr), 64'd0);
    rst_n = 1'b1;
    step();

    for (int t = 0; t < 9; t++) begin
      fill(tbl[t].kind);
      run_frame(tbl[t].vad, tbl[t].mode, tbl[t].ovr_at, fd, dc);
      chk("first_dv_cycle", 64'(fd), 64'(tbl[t].e_first));
      if (tbl[t].e_done != 0) chk("done_cycle", 64'(dc), 64'(tbl[t].e_done));
      chk("table_words", 64'(got_q.size()), 64'(tbl[t].e_words));
      if (tbl[t].chk_d0 && got_q.size() > NC)
        chk("delta0", 64'(got_q[NC].val), 64'(tbl[t].e_d0));
    end

    // Reset in the middle of EMIT: outputs clear at once, no frame_done follows.
    fill(2);
    for (int k = 0; k < NC; k++) mem[k] = DATA_W'(coef[k]);
    rmode = 0;
    frame_start = 1'b1; vad_in = 1'b1;
    step();
    frame_start = 1'b0;
    repeat (19) step();
    chk("pre_rst_dv", 64'(dv_out), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_dv", 64'(dv_out), 64'd0);
    chk("async_rst_x", 64'(x_o), 64'd0);
    chk("async_rst_idx", 64'(out_index), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    step();
    chk("rst_no_done", 64'(frame_done), 64'd0);
    step();
    rst_n = 1'b1;
    stall_pend = 1'b0;
    step();
    chk("post_rst_busy", 64'(busy), 64'd0);
    have_prev_m = 1'b0;
    for (int k = 0; k < NC; k++) prev_m[k] = 0;

    fill(0);
    run_frame(1'b1, 0, 0, fd, dc);
    chk("post_rst_first_dv", 64'(fd), 64'd14);
    if (got_q.size() == NTOT)
      for (int k = 0; k < NC; k++) chk("post_rst_delta", 64'(got_q[NC + k].val), 64'd0);

    // frame_start during DONE is ignored; the next cycle's frame_start is accepted.
    fill(2);
    run_frame(1'b1, 0, -2, fd, dc);
    chk("done_ovr_done_cycle", 64'(dc), 64'd38);
    fill(2);
    run_frame(1'b1, 0, 0, fd, dc);
    chk("after_done_first_dv", 64'(fd), 64'd14);

    for (int r = 0; r < 6; r++) begin
      fill(2);
      run_frame($urandom_range(3, 0) != 0, $urandom_range(2, 0), 0, fd, dc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
